// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM states,
// UART register map and the strobe bundle driven onto the UART component.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_SETTLE,
    ST_POLL,
    ST_GAP
  } state_t;

  localparam logic [2:0] UART_ADDR_CTRL = 3'b000;
  localparam logic [2:0] UART_ADDR_TX   = 3'b010;
  localparam int         UART_BUSY_BIT  = 1;

  // Active-low strobes plus register address, decoded as one unit per state.
  typedef struct packed {
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
  } uart_strobe_t;

  localparam uart_strobe_t STROBE_IDLE = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, addr: UART_ADDR_CTRL};

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake, status and UART component bus for uart_tx_arbiter.
// master = the arbiter, slave = requesters plus the UART component.
interface uart_tx_arbiter_if;

  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        busy;
  logic        grant_id;
  logic        timeout_err;
  logic        err_clr;
  logic        uart_cs;
  logic        uart_rd;
  logic        uart_wr;
  logic [2:0]  uart_addr;
  logic [7:0]  uart_in_data;
  logic [7:0]  uart_out_data;

  modport master (
    input  req_valid, req_data, err_clr, uart_out_data,
    output req_ready, busy, grant_id, timeout_err,
           uart_cs, uart_rd, uart_wr, uart_addr, uart_in_data
  );

  modport slave (
    output req_valid, req_data, err_clr, uart_out_data,
    input  req_ready, busy, grant_id, timeout_err,
           uart_cs, uart_rd, uart_wr, uart_addr, uart_in_data
  );

endinterface

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter: the requester that did not win last time
// takes priority on contention; a lone requester always wins.
module uart_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte sources onto one UART_Component: writes the byte to the
// TX register, then polls the busy bit until clear or until POLL_LIMIT polls.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int POLL_LIMIT = 4096
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(POLL_LIMIT + 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_grant_id;
  logic [7:0]         r_hold;
  logic [CNT_W-1:0]   r_poll_cnt;
  logic               r_timeout_err;

  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_timeout;
  logic               w_uart_busy;
  uart_strobe_t       w_strobe;

  uart_rr_arb u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_grant_id),
    .o_grant (w_grant)
  );

  assign w_uart_busy = bus.uart_out_data[UART_BUSY_BIT];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned (no latch).
    w_next    = r_state;
    w_strobe  = STROBE_IDLE;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_accept = 1'b1;
          w_next   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_strobe.cs   = 1'b0;
        w_strobe.addr = UART_ADDR_TX;
        w_next        = ST_WRITE;
      end
      ST_WRITE: begin
        w_strobe.cs   = 1'b0;
        w_strobe.wr   = 1'b0;
        w_strobe.addr = UART_ADDR_TX;
        w_next        = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Address held from the write so data/address stay stable past wr.
        w_strobe.cs   = 1'b0;
        w_strobe.addr = UART_ADDR_TX;
        w_next        = ST_POLL;
      end
      ST_POLL: begin
        w_strobe.cs   = 1'b0;
        w_strobe.rd   = 1'b0;
        w_strobe.addr = UART_ADDR_CTRL;
        w_next        = w_uart_busy ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        w_strobe.cs   = 1'b0;
        w_strobe.addr = UART_ADDR_CTRL;
        if (r_poll_cnt == CNT_W'(POLL_LIMIT)) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_POLL;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: the hold byte is a single register, not a memory, so it takes a
  // reset value; it is visible on uart_in_data straight out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_grant_id    <= 1'b1;
      r_hold        <= 8'h00;
      r_poll_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_grant[1];
        r_hold     <= w_grant[1] ? bus.req_data[15:8] : bus.req_data[7:0];
      end
      if (r_state == ST_SETTLE)
        r_poll_cnt <= '0;
      else if (r_state == ST_POLL && w_uart_busy)
        r_poll_cnt <= r_poll_cnt + CNT_W'(1);
      // A timeout in the same cycle as err_clr must leave the flag set.
      if (w_timeout)        r_timeout_err <= 1'b1;
      else if (bus.err_clr) r_timeout_err <= 1'b0;
    end
  end

  assign bus.req_ready    = w_accept ? w_grant : 2'b00;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.grant_id     = r_grant_id;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.uart_cs      = w_strobe.cs;
  assign bus.uart_rd      = w_strobe.rd;
  assign bus.uart_wr      = w_strobe.wr;
  assign bus.uart_addr    = w_strobe.addr;
  assign bus.uart_in_data = r_hold;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter POLL_LIMIT, default 4096, the maximum busy polls per byte before timeout.
REQ-002 The block SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid  input  2  per-requester "byte available" flags; bit i belongs to requester i.
REQ-005 The block SHALL have port req_data  input  16  packed bytes; requester i occupies bits [8i+7:8i].
REQ-006 The block SHALL have port req_ready  output  2  one-cycle accept pulse per requester.
REQ-007 The block SHALL have port busy  output  1  high while a byte transaction is in progress (any state other than IDLE).
REQ-008 The block SHALL have port grant_id  output  1  index of the most recently granted requester.
REQ-009 The block SHALL have port timeout_err  output  1  sticky error flag for a busy-poll timeout.
REQ-010 The block SHALL have port err_clr  input  1  synchronous clear for timeout_err.
REQ-011 The block SHALL have ports uart_cs, uart_rd, uart_wr  output  1 each  active-low UART_Component strobes.
REQ-012 The block SHALL have port uart_addr  output  3  UART register address.
REQ-013 The block SHALL have port uart_in_data  output  8  byte to transmit.
REQ-014 The block SHALL have port uart_out_data  input  8  UART read data; bit 1 is the transmitter busy bit.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, WRITE, SETTLE, POLL and GAP; uart_* outputs SHALL decode from registered state and registers only.
REQ-016 In IDLE, uart_cs, uart_rd and uart_wr SHALL all be 1 and uart_addr SHALL be 3'b000.
REQ-017 IDLE with any req_valid set: the arbiter SHALL pick one requester, pulse its req_ready in that same cycle, capture its byte into the hold register, update grant_id, and go to SETUP.
REQ-018 Arbitration SHALL be round-robin: the requester not equal to grant_id wins when both are valid; a lone valid requester always wins.
REQ-019 SETUP: cs=0, wr=1, rd=1, addr=3'b010, uart_in_data=hold; next state WRITE.
REQ-020 WRITE: cs=0, wr=0, addr=3'b010; next state SETTLE.
REQ-021 SETTLE: cs=0, all other strobes inactive; next state POLL; the poll counter SHALL be cleared here.
REQ-022 POLL: cs=0, rd=0, addr=3'b000.
REQ-023 In POLL, if uart_out_data[1]==0 the FSM SHALL go to IDLE; otherwise it SHALL increment the poll counter and go to GAP.
REQ-024 GAP: cs=0, rd=1. If the poll counter equals POLL_LIMIT, timeout_err SHALL be set and the FSM SHALL go to IDLE; otherwise it SHALL go to POLL.
REQ-025 Timing SHALL be: accept at cycle N, wr low at N+2, first poll at N+4, minimum 5 cycles per byte, with IDLE able to re-grant on the cycle after completion.
REQ-026 uart_in_data SHALL hold the captured byte from SETUP until the next grant.
REQ-027 req_valid dropping before it is granted SHALL be legal and SHALL have no effect.
REQ-028 req_valid SHALL be ignored outside IDLE, and req_ready SHALL be 0 outside IDLE.
REQ-029 When err_clr and a timeout occur in the same cycle, the set SHALL win.
REQ-030 timeout_err SHALL NOT block further grants.
REQ-031 The poll counter SHALL be sized for POLL_LIMIT without wrap.

Reset
REQ-032 On reset low, the block SHALL immediately enter IDLE.
REQ-033 Reset values SHALL be: grant_id=1 (so requester 0 wins first), hold=0, poll counter=0, timeout_err=0, req_ready=0, busy=0, strobes=1, addr=000, in_data=0.
REQ-034 A reset asserted mid-transaction SHALL abort it with no further strobes; the aborted byte SHALL be dropped and not retried.

Structure
REQ-035 Package uart_ctrl_pkg SHALL hold the state enum, UART_ADDR_CTRL=3'b000, UART_ADDR_TX=3'b010, and UART_BUSY_BIT=1.
REQ-036 A single sub-module, uart_rr_arb, SHALL implement the 2-way round-robin arbiter (req, last grant -> one-hot grant).

Verification
REQ-037 Single byte: req_valid=01, data 8'h4F, UART busy for 20 cycles -> ready[0] pulses once, wr low exactly one cycle with addr 010 and in_data 4F, polls at addr 000 until busy clears, then IDLE.
REQ-038 Contention: both valid continuously, data 8'h41 / 8'h42 -> grants alternate 0,1,0,1 and UART receives 41,42,41,42.
REQ-039 Timeout: POLL_LIMIT=8, busy bit stuck at 1 -> timeout_err sets after the 8th poll and FSM returns to IDLE; err_clr in a later cycle clears it, and err_clr in the same cycle as the timeout leaves it set.
REQ-040 Reset during the POLL of byte 8'h55 -> all strobes go high the same cycle; after release, a new request 8'h33 from requester 1 completes normally.
REQ-041 Fast UART (busy already 0 at first poll): back-to-back bytes from requester 1 -> accepts 5 cycles apart, exactly one read strobe per byte.
